// File: rtl/clock_set_controller.sv
// Time-set controller: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> COMMIT (one-cycle load) -> RUN.
// Define SET_TIMEOUT_EN to abort an idle edit back to RUN after TIMEOUT_CYCLES.
module clock_set_controller #(
  parameter int BLINK_HALF_CYCLES = 25_000_000,
  parameter int TIMEOUT_CYCLES    = 1_000_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [5:0] i_cur_hour,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic       o_run,
  output logic       o_load,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_edit_field,
  output logic [3:0] o_blank_mask
);
  localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [5:0]    hour, min, sec;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          in_set, set_nxt, step, any_btn, timeout;

  assign in_set  = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
  assign set_nxt = (state_nxt == SET_HOUR) || (state_nxt == SET_MIN) || (state_nxt == SET_SEC);
  assign step    = i_btn_up ^ i_btn_down;
  assign any_btn = i_btn_mode | i_btn_up | i_btn_down;

  function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] top, input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

`ifdef SET_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) idle_cnt <= '0;
    else if (!in_set || any_btn || state_nxt != state) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout = in_set && !any_btn && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Constant false; the comparison only keeps the parameter referenced.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= RUN;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (i_btn_mode) state_nxt = SET_HOUR;
      SET_HOUR: if (timeout) state_nxt = RUN; else if (i_btn_mode) state_nxt = SET_MIN;
      SET_MIN:  if (timeout) state_nxt = RUN; else if (i_btn_mode) state_nxt = SET_SEC;
      SET_SEC:  if (timeout) state_nxt = RUN; else if (i_btn_mode) state_nxt = COMMIT;
      COMMIT:   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Mode wins over up/down in the same cycle, so a step is taken only without mode.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      hour <= '0;
      min  <= '0;
      sec  <= '0;
    end else begin
      case (state)
        RUN: if (i_btn_mode) begin
          hour <= (i_cur_hour > 6'd23) ? 6'd0 : i_cur_hour;
          min  <= (i_cur_min  > 6'd59) ? 6'd0 : i_cur_min;
          sec  <= (i_cur_sec  > 6'd59) ? 6'd0 : i_cur_sec;
        end
        SET_HOUR: if (!i_btn_mode && step) hour <= bump(hour, 6'd23, i_btn_up);
        SET_MIN:  if (!i_btn_mode && step) min  <= bump(min,  6'd59, i_btn_up);
        SET_SEC:  if (!i_btn_mode && step) sec  <= bump(sec,  6'd59, i_btn_up);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!set_nxt || state_nxt != state || (in_set && step)) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    o_run        = (state == RUN);
    o_load       = (state == COMMIT);
    o_edit_field = 2'd0;
    o_blank_mask = 4'b0000;
    case (state)
      SET_HOUR: begin o_edit_field = 2'd1; if (phase) o_blank_mask = 4'b1100; end
      SET_MIN:  begin o_edit_field = 2'd2; if (phase) o_blank_mask = 4'b0011; end
      SET_SEC:  begin o_edit_field = 2'd3; if (phase) o_blank_mask = 4'b1100; end
      default: ;
    endcase
  end

  assign o_hour = hour;
  assign o_min  = min;
  assign o_sec  = sec;
endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: table of per-cycle vectors with a scoreboard queue,
// followed by an idle run in SET_SEC that exercises the optional edit timeout.
module tb_clock_set_controller;
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_btn_mode = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
  logic [5:0] i_cur_hour = '0, i_cur_min = '0, i_cur_sec = '0;
  logic       o_run, o_load;
  logic [5:0] o_hour, o_min, o_sec;
  logic [1:0] o_edit_field;
  logic [3:0] o_blank_mask;

  always #5 i_clk = ~i_clk;

  clock_set_controller #(.BLINK_HALF_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_btn_mode(i_btn_mode), .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
    .i_cur_hour(i_cur_hour), .i_cur_min(i_cur_min), .i_cur_sec(i_cur_sec),
    .o_run(o_run), .o_load(o_load), .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
    .o_edit_field(o_edit_field), .o_blank_mask(o_blank_mask)
  );

  typedef struct {
    logic        rst_n, mode, up, dn;
    logic [5:0]  ch, cm, cs;
    logic [25:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] exp_q[$];
  logic [5:0]  fh, fm, fs;
  int          checks = 0;
  int          errors = 0;

  wire logic [25:0] act = {o_run, o_load, o_hour, o_min, o_sec, o_edit_field, o_blank_mask};

  function automatic void add(input logic r, md, u, d, input logic run, ld,
                              input int h, m, s, f, input logic [3:0] mask);
    vec_t v;
    v.rst_n = r; v.mode = md; v.up = u; v.dn = d;
    v.ch = fh; v.cm = fm; v.cs = fs;
    v.exp = {run, ld, 6'(h), 6'(m), 6'(s), 2'(f), mask};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int exit_at;
    logic saw_load;

    // Reset, RUN ignores up, capture 13:45:07, hour wrap up and down, hour blink.
    fh = 13; fm = 45; fs = 7;
    add(0,0,0,0, 1,0, 0,0,0, 0, 4'b0000);
    add(0,0,0,0, 1,0, 0,0,0, 0, 4'b0000);
    add(1,0,0,0, 1,0, 0,0,0, 0, 4'b0000);
    add(1,0,1,0, 1,0, 0,0,0, 0, 4'b0000);
    add(1,1,0,0, 0,0, 13,45,7, 1, 4'b0000);
    for (int i = 1; i <= 11; i++) add(1,0,1,0, 0,0, (13 + i) % 24,45,7, 1, 4'b0000);
    add(1,0,0,1, 0,0, 23,45,7, 1, 4'b0000);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0, 23,45,7, 1, 4'b0000);
    add(1,0,0,0, 0,0, 23,45,7, 1, 4'b1100);
    add(1,0,1,0, 0,0, 0,45,7, 1, 4'b0000);
    add(1,0,0,1, 0,0, 23,45,7, 1, 4'b0000);
    add(1,0,1,1, 0,0, 23,45,7, 1, 4'b0000);
    add(1,1,1,0, 0,0, 23,45,7, 2, 4'b0000);
    add(1,0,1,1, 0,0, 23,45,7, 2, 4'b0000);
    add(1,0,0,1, 0,0, 23,44,7, 2, 4'b0000);
    add(1,1,0,0, 0,0, 23,44,7, 3, 4'b0000);
    add(1,0,1,0, 0,0, 23,44,8, 3, 4'b0000);
    add(1,0,1,0, 0,0, 23,44,9, 3, 4'b0000);
    add(1,1,0,0, 0,1, 23,44,9, 0, 4'b0000);
    add(1,1,1,0, 1,0, 23,44,9, 0, 4'b0000);
    add(1,0,0,0, 1,0, 23,44,9, 0, 4'b0000);

    // Capture 23:00:07, minute blink and 0->59 wrap, commit 23:59:09.
    fh = 23; fm = 0; fs = 7;
    add(1,1,0,0, 0,0, 23,0,7, 1, 4'b0000);
    add(1,1,0,0, 0,0, 23,0,7, 2, 4'b0000);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0, 23,0,7, 2, 4'b0000);
    for (int i = 0; i < 2; i++) add(1,0,0,0, 0,0, 23,0,7, 2, 4'b0011);
    add(1,0,0,1, 0,0, 23,59,7, 2, 4'b0000);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0, 23,59,7, 2, 4'b0000);
    add(1,0,0,0, 0,0, 23,59,7, 2, 4'b0011);
    add(1,1,0,0, 0,0, 23,59,7, 3, 4'b0000);
    add(1,0,1,0, 0,0, 23,59,8, 3, 4'b0000);
    add(1,0,1,0, 0,0, 23,59,9, 3, 4'b0000);
    add(1,1,0,0, 0,1, 23,59,9, 0, 4'b0000);
    add(1,0,0,0, 1,0, 23,59,9, 0, 4'b0000);

    // Out-of-range live values capture as zero.
    fh = 30; fm = 60; fs = 63;
    add(1,1,0,0, 0,0, 0,0,0, 1, 4'b0000);
    add(1,1,0,0, 0,0, 0,0,0, 2, 4'b0000);
    add(1,1,0,0, 0,0, 0,0,0, 3, 4'b0000);
    add(1,1,0,0, 0,1, 0,0,0, 0, 4'b0000);
    add(1,0,0,0, 1,0, 0,0,0, 0, 4'b0000);

    // Reset held three cycles in SET_MIN after editing hour to 5.
    fh = 4; fm = 10; fs = 20;
    add(1,1,0,0, 0,0, 4,10,20, 1, 4'b0000);
    add(1,0,1,0, 0,0, 5,10,20, 1, 4'b0000);
    add(1,1,0,0, 0,0, 5,10,20, 2, 4'b0000);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 1,0, 0,0,0, 0, 4'b0000);
    add(1,0,0,0, 1,0, 0,0,0, 0, 4'b0000);

    // Walk into SET_SEC for the idle run below.
    fh = 1; fm = 2; fs = 3;
    add(1,1,0,0, 0,0, 1,2,3, 1, 4'b0000);
    add(1,1,0,0, 0,0, 1,2,3, 2, 4'b0000);
    add(1,1,0,0, 0,0, 1,2,3, 3, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      i_reset    = vecs[i].rst_n;
      i_btn_mode = vecs[i].mode;
      i_btn_up   = vecs[i].up;
      i_btn_down = vecs[i].dn;
      i_cur_hour = vecs[i].ch;
      i_cur_min  = vecs[i].cm;
      i_cur_sec  = vecs[i].cs;
      exp_q.push_back(vecs[i].exp);
      @(posedge i_clk);
      #1;
      begin
        logic [25:0] e;
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL vec%0d: got run=%0b load=%0b %0d:%0d:%0d field=%0d mask=%b expected run=%0b load=%0b %0d:%0d:%0d field=%0d mask=%b",
                   i, act[25], act[24], act[23:18], act[17:12], act[11:6], act[5:4], act[3:0],
                   e[25], e[24], e[23:18], e[17:12], e[11:6], e[5:4], e[3:0]);
        end
      end
    end

    // Idle in SET_SEC with no buttons.
    i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
    exit_at  = 0;
    saw_load = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge i_clk);
      #1;
      if (o_load) saw_load = 1'b1;
      if (exit_at == 0 && o_edit_field == 2'd0) exit_at = k;
    end
    chk("idle_no_load", int'(saw_load), 0);
`ifdef SET_TIMEOUT_EN
    chk("timeout_exit_cycle", exit_at, 16);
    chk("timeout_run", int'(o_run), 1);
    chk("timeout_mask", int'(o_blank_mask), 0);
`else
    chk("no_timeout_exit", exit_at, 0);
    chk("no_timeout_field", int'(o_edit_field), 3);
    chk("no_timeout_run", int'(o_run), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-set controller for the FND time clock. Sequences the time counter between normal counting and a user edit mode. In edit mode, captures the current hour/min/sec, lets buttons step each field, and commits the result back through a one-cycle load pulse.
- Drives the counter run-enable and load port. Also drives a digit-blank mask, which the FND digit decoder uses to blink the field being edited.
- Sits between the debounced button logic and the time counter / digit path.

Parameters:
- BLINK_HALF_CYCLES, 25_000_000: i_clk cycles per blink half-period (250 ms at 100 MHz).
- TIMEOUT_CYCLES, 1_000_000_000: idle i_clk cycles before edit abort. Used only with SET_TIMEOUT_EN.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_btn_mode  input  1  single-cycle pulse, debounced; enter edit / advance field.
- i_btn_up  input  1  single-cycle pulse; increment edited field.
- i_btn_down  input  1  single-cycle pulse; decrement edited field.
- i_cur_hour  input  6  live hour from counter, 0..23.
- i_cur_min  input  6  live minute, 0..59.
- i_cur_sec  input  6  live second, 0..59.
- o_run  output  1  counter enable; 1 = counting.
- o_load  output  1  one-cycle pulse; counter loads o_hour/o_min/o_sec and clears msec.
- o_hour  output  6  edit/load hour value.
- o_min  output  6  edit/load minute value.
- o_sec  output  6  edit/load second value.
- o_edit_field  output  2  0 none, 1 hour, 2 min, 3 sec.
- o_blank_mask  output  4  1 = blank digit; bit3 = leftmost digit.

Behaviour:
- All outputs are registered. Every input event at edge N appears on the outputs after edge N.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- Reset (i_reset=0 at an edge), including mid-edit:
  - state goes to RUN; o_run=1; o_load=0; o_hour/o_min/o_sec=0; o_edit_field=0; o_blank_mask=0.
  - blink and idle counters clear; pending edits are discarded.
- RUN:
  - o_run=1.
  - i_btn_mode → SET_HOUR. On that edge, capture i_cur_* into the edit registers. Any captured value out of range (hour>23, min/sec>59) is captured as 0.
  - Also on that edge: o_run=0, o_edit_field=1.
  - up/down are ignored.
- SET_HOUR / SET_MIN / SET_SEC:
  - o_run=0.
  - up: field+1, wrapping 23→0 for hour and 59→0 for min/sec.
  - down: field−1, wrapping 0→23 for hour and 0→59 for min/sec.
  - up and down in the same cycle: no change.
  - i_btn_mode has priority over up/down in the same cycle. The up/down in that cycle is dropped.
  - mode transitions: SET_HOUR→SET_MIN, SET_MIN→SET_SEC, SET_SEC→COMMIT.
- COMMIT:
  - Lasts exactly one cycle: o_load=1 with the edit values on o_hour/o_min/o_sec, o_run=0.
  - Next state is RUN with o_load=0, o_run=1, o_edit_field=0.
  - Buttons are ignored during COMMIT.
- o_hour/o_min/o_sec hold their last edit value in RUN. The counter samples them only when o_load=1.
- Blink:
  - The blink counter runs only in SET states and toggles phase every BLINK_HALF_CYCLES cycles.
  - Phase is forced to visible (0) and the counter is cleared on entry to each SET state and on every accepted up/down press.
  - When phase=1, o_blank_mask is:
    - SET_HOUR: 4'b1100
    - SET_MIN: 4'b0011
    - SET_SEC: 4'b1100 (display in sec/msec mode)
  - When phase=0, or in RUN/COMMIT, o_blank_mask=4'b0000.
- Blink counter width is $clog2(BLINK_HALF_CYCLES). Edit arithmetic is 6-bit, with wrap handled explicitly, never by overflow.

Optional Feature:
- Macro: SET_TIMEOUT_EN.
- Defined:
  - An idle counter runs in SET states and clears on any button pulse or on state entry.
  - On reaching TIMEOUT_CYCLES−1, the next edge goes to RUN with no o_load pulse. Edits are discarded, o_run=1, o_edit_field=0, o_blank_mask=0.
- Not defined: no idle counter exists, and SET states persist indefinitely.

Test Plan:
- Reset held 3 cycles mid SET_MIN with hour edited to 5 → state RUN, o_run=1, o_load=0, o_hour=0, o_blank_mask=0.
- i_cur=13:45:07, pulse mode → next cycle o_run=0, o_edit_field=1, o_hour=13; up ×11 → o_hour=0 (wrap at 23→0); down ×1 → 23.
- Full sequence: mode, mode, down from min=0 → o_min=59; mode, up ×2 from sec=7 → 9; mode → exactly one cycle o_load=1 carrying 23:59:09, then o_run=1, o_edit_field=0.
- Same-cycle mode+up in SET_HOUR → field unchanged, state SET_MIN. Same-cycle up+down → no change.
- BLINK_HALF_CYCLES=4, in SET_MIN → o_blank_mask alternates 0000/0011 every 4 cycles. An up press forces 0000 and restarts the count.
- With SET_TIMEOUT_EN, TIMEOUT_CYCLES=16, no buttons in SET_SEC → RUN after 16 cycles, o_load never asserted, o_run=1. Without the macro → still SET_SEC after 1000 cycles.
